mux10_rr_arbiter: RTL

MUX10_RR_ARBITER -- requirements
Module: mux10_rr_arbiter

---
 rtl/mux10_rr_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mux10_rr_arbiter.sv
// Ten-requester round-robin arbiter feeding a single registered output word
// with a valid/ready handshake and a saturating transfer counter.
module mux10_rr_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [9:0]           req_i,
    input  logic [10*DATA_W-1:0] data_i,
    output logic [9:0]           gnt_o,
    output logic [3:0]           sel_o,
    output logic                 out_valid_o,
    output logic [DATA_W-1:0]    out_data_o,
    input  logic                 out_ready_i,
    output logic [15:0]          xfer_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [3:0]          r_ptr;
    logic [3:0]          r_sel;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_cnt;

    logic                w_found;
    logic [3:0]          w_idx;
    logic                w_load;
    logic [9:0]          w_gnt;
    logic [DATA_W-1:0]   w_word;
    logic [3:0]          w_ptr_nxt;
    logic                w_xfer;

    // Scan ptr, ptr+1, ..., wrapping modulo 10; first set request wins.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= 10) idx = idx - 10;
            if (!w_found && req_i[idx]) begin
                w_found = 1'b1;
                w_idx   = 4'(idx);
            end
        end
    end

    // rst_ni gates the load so gnt_o drops immediately on async reset.
    assign w_load = rst_ni && w_found && ((r_state == IDLE) || out_ready_i);
    assign w_xfer = (r_state == BUSY) && out_ready_i;

    always_comb begin
        w_gnt  = '0;
        w_word = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (w_idx == 4'(i)) begin
                w_gnt[i] = w_load;
                w_word   = data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_nxt = (w_idx == 4'd9) ? 4'd0 : w_idx + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '1;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_state <= BUSY;
                r_data  <= w_word;
                r_sel   <= w_idx;
                r_ptr   <= w_ptr_nxt;
            end else if (w_xfer) begin
                r_state <= IDLE;
                r_sel   <= '1;
            end
            if (w_xfer && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign sel_o       = r_sel;
    assign out_valid_o = (r_state == BUSY);
    assign out_data_o  = r_data;
    assign xfer_cnt_o  = r_cnt;

endmodule
